// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register and one-entry hold buffer.
// Define IF_PERF_EN to add the fetch_count/bubble_count counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [5:0]  if_opcode,
  output logic [31:0] if_pc4
`ifdef IF_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_HOLD,
    S_DRAIN
  } state_t;

  localparam logic [31:0] BOOT_PC = RESET_PC & 32'hFFFF_FFFC;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc4;

  logic        redir;
  logic [31:0] target;
  logic [31:0] req_pc4;
  logic        load_mem;
  logic        load_buf;
  logic        to_hold;

  assign redir     = branch_taken | jump_en;
  assign target    = (branch_taken ? branch_target : jump_target)
                   & 32'hFFFF_FFFC;
  assign req_pc4   = req_addr + 32'd4;
  assign imem_addr = req_addr;
  assign if_opcode = if_instr[31:26];

  always_comb begin
    load_mem = 1'b0;
    load_buf = 1'b0;
    to_hold  = 1'b0;
    if (state == S_REQ && imem_ready && !redir) begin
      load_mem = !if_valid || !stall;
      to_hold  = if_valid && stall;
    end
    if (state == S_HOLD && !redir && !stall)
      load_buf = 1'b1;
  end

  // IF/ID register: flush beats stall, stall beats drain-to-empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid <= 1'b0;
      if_instr <= 32'h0;
      if_pc4   <= 32'h0;
    end else if (redir) begin
      if_valid <= 1'b0;
    end else if (load_mem) begin
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc4   <= req_pc4;
    end else if (load_buf) begin
      if_valid <= 1'b1;
      if_instr <= hold_instr;
      if_pc4   <= hold_pc4;
    end else if (!stall) begin
      if_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_BOOT;
      pc         <= BOOT_PC;
      req_addr   <= BOOT_PC;
      imem_req   <= 1'b0;
      hold_instr <= 32'h0;
      hold_pc4   <= 32'h0;
    end else begin
      unique case (state)
        S_BOOT: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
          if (redir) begin
            pc       <= target;
            req_addr <= target;
          end else begin
            req_addr <= pc;
          end
        end
        S_REQ: begin
          if (imem_ready) begin
            if (redir) begin
              pc       <= target;
              req_addr <= target;
            end else if (to_hold) begin
              hold_instr <= imem_rdata;
              hold_pc4   <= req_pc4;
              pc         <= req_pc4;
              state      <= S_HOLD;
              imem_req   <= 1'b0;
            end else begin
              pc       <= req_pc4;
              req_addr <= req_pc4;
            end
          end else if (redir) begin
            // address must stay put until memory answers
            pc    <= target;
            state <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (redir) begin
            pc       <= target;
            req_addr <= target;
            state    <= S_REQ;
            imem_req <= 1'b1;
          end else if (!stall) begin
            req_addr <= pc;
            state    <= S_REQ;
            imem_req <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (redir)
            pc <= target;
          if (imem_ready) begin
            req_addr <= redir ? target : pc;
            state    <= S_REQ;
          end
        end
        default: begin
          state    <= S_BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count  <= 32'h0;
      bubble_count <= 32'h0;
    end else begin
      if (load_mem || load_buf)
        fetch_count <= fetch_count + 32'd1;
      if (!if_valid && !stall)
        bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage with the IF/ID pipeline register. It sequences the program counter, runs a request/ready handshake with instruction memory, and holds the fetched word plus PC+4 for decode. `if_opcode` drives the main control decoder directly. Branch/jump redirects from later stages flush in-flight work, and a decode stall back-pressures fetch through a one-entry holding buffer.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] ignored.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `imem_req` out 1: fetch request; held with a stable `imem_addr` until `imem_ready`.
- `imem_addr` out 32: word-aligned fetch address, bits [1:0] always 0.
- `imem_ready` in 1: `imem_rdata` valid this cycle; completes the request.
- `imem_rdata` in 32: instruction word.
- `stall` in 1: decode cannot accept; hold IF/ID.
- `branch_taken` in 1, `branch_target` in 32: branch redirect.
- `jump_en` in 1, `jump_target` in 32: jump redirect.
- `if_valid` out 1: IF/ID holds a live instruction.
- `if_instr` out 32: IF/ID instruction.
- `if_opcode` out 6: `if_instr[31:26]`, combinational.
- `if_pc4` out 32: address of `if_instr` + 4.
- `fetch_count` out 32, `bubble_count` out 32: present only with `IF_PERF_EN`.

## Operation
- **Redirect:**
  - `redir = branch_taken | jump_en`.
  - Target = `branch_taken ? branch_target : jump_target`, with bits [1:0] forced to 0. Branch wins if both are asserted.
- **Registers:** `pc` (next fetch address), `req_addr` (drives `imem_addr`), buffer (instr, pc4), state.
- **Arithmetic:** pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- **BOOT** (reset state):
  - `imem_req`=0.
  - Next cycle → REQ with `req_addr`=`pc`.
- **REQ:**
  - `imem_req`=1.
  - `imem_ready` & redir: drop data, `pc`/`req_addr`←target, stay in REQ.
  - `imem_ready` & !redir & (!`if_valid` | !`stall`): IF/ID←{rdata, req_addr+4}, `if_valid`←1, `pc`/`req_addr`←req_addr+4.
  - `imem_ready` & !redir & `if_valid` & `stall`: buffer←{rdata, req_addr+4}, `pc`←req_addr+4, go to HOLD.
  - !`imem_ready` & redir: `pc`←target, go to DRAIN; `req_addr` is unchanged.
- **HOLD:**
  - `imem_req`=0.
  - redir: discard buffer, `pc`/`req_addr`←target, go to REQ.
  - else !`stall`: IF/ID←buffer, `if_valid`←1, `req_addr`←`pc`, go to REQ.
- **DRAIN:**
  - `imem_req`=1 on the old `req_addr`.
  - Further redir: `pc`←newest target.
  - `imem_ready`: discard data, `req_addr`←`pc`, go to REQ. If redir also occurs that cycle, the newest target is used.
- **IF/ID register:**
  - redir forces `if_valid`←0 regardless of `stall`; flush wins.
  - `stall` & !redir: hold all fields.
  - !`stall` with no new word: `if_valid`←0.
- **Reset values:** `if_valid`=0, `if_instr`=0, `if_pc4`=0, `imem_req`=0, `imem_addr`=`RESET_PC`, counters 0. Reset mid-request abandons the request; memory must tolerate request withdrawal on reset only.

## Timing
- Zero-wait memory (ready in the request cycle): one instruction per cycle; `if_valid` rises 2 cycles after reset release.
- Fetch-to-decode latency: the word is visible on `if_instr` the cycle after `imem_ready`.
- Redirect to first new request: the next cycle from REQ/HOLD; from DRAIN, the cycle after the outstanding `imem_ready`.
- Request stability: once `imem_req`=1, `imem_addr` is constant until the `imem_ready` cycle.
- `imem_ready` while `imem_req`=0 is ignored.

## Configuration
- `IF_PERF_EN` defined:
  - `fetch_count` increments on each IF/ID load with `if_valid`←1.
  - `bubble_count` increments on each cycle with `if_valid`=0 and !`stall`.
  - Both wrap at 2^32 and reset to 0.
- `IF_PERF_EN` undefined: both ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset with `RESET_PC`=32'h0040_0000 and zero-wait memory → addresses 0x00400000, 0x00400004, … each cycle; `if_pc4`=0x00400004 on the first valid cycle.
- Memory ready after 3 cycles → `imem_addr` stable for all 3 cycles; `if_valid` pulses for exactly one cycle per completed fetch with no stall.
- `stall` held 4 cycles while `if_valid`=1 and fetch completes → word goes to buffer, `imem_req`=0 in HOLD, released in order after `stall` drops, no loss or duplication.
- `jump_en` with `jump_target`=0x00000102 while a request is pending → DRAIN; the old data is discarded; next `imem_addr`=0x00000100; `if_valid`=0 the cycle after the redirect.
- `branch_taken` (0x200) and `jump_en` (0x300) together in the same cycle as a `stall` → IF/ID flushed, next fetch at 0x200.
- Reset asserted mid-DRAIN → all outputs at reset values immediately; with `IF_PERF_EN`, counters read 0.
